video_pattern_gen: RTL and testbench

- Synthesizable, parametrised video timing generator with a built-in test-pattern source.
- Successor to the fixed 1080p simulation image source. Adds programmable porch, sync and active sizes, sync polarity, run/stop control and selectable patterns.
- Outputs vs, hs, de, rgb and frame markers, all aligned on one pipeline stage. Drives the image-processing pipeline input in simulation and on the FPGA.

---
 rtl/video_pattern_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pattern_gen : programmable video timing generator with test patterns  |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module video_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                en,
  input  logic [2:0]          mode,
  input  logic [3*DATA_W-1:0] solid_rgb,
  output logic                vs,
  output logic                hs,
  output logic                de,
  output logic [DATA_W-1:0]   r,
  output logic [DATA_W-1:0]   g,
  output logic [DATA_W-1:0]   b,
  output logic                sof,
  output logic                eol,
  output logic [15:0]         frame_cnt
);

  localparam int C_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int C_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int C_H_ACT0  = H_SYNC + H_BP;
  localparam int C_V_ACT0  = V_SYNC + V_BP;
  localparam int C_HW      = $clog2(C_H_TOTAL);
  localparam int C_VW      = $clog2(C_V_TOTAL);
  localparam int C_BAR_W   = H_ACTIVE / 8;
  localparam int C_BW      = $clog2(H_ACTIVE + 1);
  localparam logic [DATA_W-1:0] C_FULL = '1;

  // ARM gives one idle cycle between the start request and counter (0,0)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [C_HW-1:0]     r_h_cnt;
  logic [C_HW-1:0]     w_h_nxt;
  logic [C_VW-1:0]     r_v_cnt;
  logic [C_VW-1:0]     w_v_nxt;
  logic [2:0]          r_mode;
  logic [3*DATA_W-1:0] r_solid;
  logic [C_BW-1:0]     r_bar_cnt;
  logic [2:0]          r_bar_idx;

  logic                w_run;
  logic                w_h_last;
  logic                w_v_last;
  logic                w_frame_end;
  logic                w_latch;
  logic                w_h_in;
  logic                w_v_in;
  logic                w_hs_act;
  logic                w_vs_act;
  logic                w_de;
  logic                w_sof;
  logic                w_eol;
  logic                w_chk;
  logic [C_HW-1:0]     w_x;
  logic [C_VW-1:0]     w_y;
  logic [DATA_W-1:0]   w_pr;
  logic [DATA_W-1:0]   w_pg;
  logic [DATA_W-1:0]   w_pb;

  assign w_run       = (r_state == S_RUN);
  assign w_h_last    = (r_h_cnt == C_HW'(C_H_TOTAL - 1));
  assign w_v_last    = (r_v_cnt == C_VW'(C_V_TOTAL - 1));
  assign w_frame_end = w_run && w_h_last && w_v_last;
  assign w_latch     = en && ((r_state == S_IDLE) || w_frame_end);

  assign w_h_in = (r_h_cnt >= C_HW'(C_H_ACT0)) &&
                  ({1'b0, r_h_cnt} < (C_HW + 1)'(C_H_ACT0 + H_ACTIVE));
  assign w_v_in = (r_v_cnt >= C_VW'(C_V_ACT0)) &&
                  ({1'b0, r_v_cnt} < (C_VW + 1)'(C_V_ACT0 + V_ACTIVE));
  assign w_x    = r_h_cnt - C_HW'(C_H_ACT0);
  assign w_y    = r_v_cnt - C_VW'(C_V_ACT0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_end && !en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (w_run) begin
      w_h_nxt = w_h_last ? '0 : r_h_cnt + C_HW'(1);
      if (w_h_last) begin
        w_v_nxt = w_v_last ? '0 : r_v_cnt + C_VW'(1);
      end else begin
        w_v_nxt = r_v_cnt;
      end
    end
  end

  // Bar index tracks the current counter position, so it steps with h_cnt
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_mode    <= '0;
      r_solid   <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      frame_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      if (w_latch) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      if (w_frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (w_h_nxt == C_HW'(C_H_ACT0)) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (w_h_in) begin
        if (r_bar_cnt == C_BW'(C_BAR_W - 1)) begin
          r_bar_cnt <= '0;
          if (r_bar_idx != 3'd7) begin
            r_bar_idx <= r_bar_idx + 3'd1;
          end
        end else begin
          r_bar_cnt <= r_bar_cnt + C_BW'(1);
        end
      end
    end
  end

  always_comb begin
    w_hs_act = w_run && (r_h_cnt < C_HW'(H_SYNC));
    w_vs_act = w_run && (r_v_cnt < C_VW'(V_SYNC));
    w_de     = w_run && w_h_in && w_v_in;
    w_sof    = w_de && (w_x == '0) && (w_y == '0);
    w_eol    = w_de && (w_x == C_HW'(H_ACTIVE - 1));
    w_chk    = (((w_x >> CHK_LOG2) & C_HW'(1)) != '0) ^
               (((w_y >> CHK_LOG2) & C_VW'(1)) != '0);
    w_pr     = '0;
    w_pg     = '0;
    w_pb     = '0;
    if (w_de) begin
      case (r_mode)
        3'd0: {w_pr, w_pg, w_pb} = r_solid;
        // white, yellow, cyan, green, magenta, red, blue, black
        3'd1: begin
          w_pr = {DATA_W{~r_bar_idx[1]}};
          w_pg = {DATA_W{~r_bar_idx[2]}};
          w_pb = {DATA_W{~r_bar_idx[0]}};
        end
        3'd2: begin
          w_pr = DATA_W'(w_x);
          w_pg = DATA_W'(w_x);
          w_pb = DATA_W'(w_x);
        end
        3'd3: begin
          w_pr = w_chk ? C_FULL : '0;
          w_pg = w_chk ? C_FULL : '0;
          w_pb = w_chk ? C_FULL : '0;
        end
        3'd4: begin
          w_pr = DATA_W'(w_x) + DATA_W'(frame_cnt);
          w_pg = DATA_W'(w_y);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vs  <= ~VS_POL;
      hs  <= ~HS_POL;
      de  <= 1'b0;
      r   <= '0;
      g   <= '0;
      b   <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
    end else begin
      vs  <= w_vs_act ? VS_POL : ~VS_POL;
      hs  <= w_hs_act ? HS_POL : ~HS_POL;
      de  <= w_de;
      r   <= w_pr;
      g   <= w_pg;
      b   <= w_pb;
      sof <= w_sof;
      eol <= w_eol;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_pattern_gen : directed self-checking bench, 25x8 total raster      |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_video_pattern_gen;

  logic        clk;
  logic        rst_b;
  logic        en;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic        vs;
  logic        hs;
  logic        de;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        sof;
  logic        eol;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int hs_low0, hs_low, vs_low, de_cnt, sof_cnt, eol_cnt, first_de;
  logic [23:0] bar_exp [8];

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(8), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vs(vs), .hs(hs), .de(de), .r(r), .g(g), .b(b),
    .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bar_exp[0] = 24'hFFFFFF; bar_exp[1] = 24'hFFFF00;
    bar_exp[2] = 24'h00FFFF; bar_exp[3] = 24'h00FF00;
    bar_exp[4] = 24'hFF00FF; bar_exp[5] = 24'hFF0000;
    bar_exp[6] = 24'h0000FF; bar_exp[7] = 24'h000000;

    rst_b = 1'b1; en = 1'b0; mode = 3'd2; solid_rgb = 24'h0;
    #2 rst_b = 1'b0;
    step(); step();
    chk("rst_vs", vs, 1); chk("rst_hs", hs, 1); chk("rst_de", de, 0);
    chk("rst_rgb", {r, g, b}, 0); chk("rst_sof_eol", {sof, eol}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_b = 1'b1;
    step(); step(); step();
    chk("idle_hs", hs, 1); chk("idle_vs", vs, 1);

    // start: en sampled at the next edge k
    en = 1'b1;
    step(); chk("lat_k_hs", hs, 1);
    step(); chk("lat_k1_hs", hs, 1); chk("lat_k1_vs", vs, 1);
    step();
    n = 0;
    chk("lat_k2_hs", hs, 0); chk("lat_k2_vs", vs, 0);

    hs_low0 = 0; hs_low = 0; vs_low = 0; de_cnt = 0;
    sof_cnt = 0; eol_cnt = 0; first_de = -1;
    for (int i = 0; i < 200; i++) begin
      if (i != 0) step();
      if (!hs) hs_low++;
      if (!hs && i < 25) hs_low0++;
      if (!vs) vs_low++;
      if (de) de_cnt++;
      if (sof) sof_cnt++;
      if (eol) eol_cnt++;
      if (de && first_de < 0) first_de = i;
      if (i == 10) mode = 3'd1;
      if (i == 81) chk("f0_pre_de_rgb", {de, r, g, b}, 0);
      if (i == 82) begin
        chk("f0_px0_rgb", {r, g, b}, 0); chk("f0_sof", sof, 1);
      end
      if (i == 83) chk("f0_px1_ramp", {r, g, b}, 24'h010101);
      if (i == 97) begin
        chk("f0_px15_ramp", {r, g, b}, 24'h0F0F0F); chk("f0_eol", eol, 1);
      end
      if (i == 98) chk("f0_fp_de", {de, r, g, b}, 0);
      if (i == 198) chk("f0_fcnt_before", frame_cnt, 0);
    end
    chk("f0_fcnt_end", frame_cnt, 1);
    chk("f0_hs_line0", hs_low0, 3);
    chk("f0_hs_total", hs_low, 24);
    chk("f0_vs_low", vs_low, 50);
    chk("f0_de_cnt", de_cnt, 64);
    chk("f0_first_de", first_de, 82);
    chk("f0_sof_cnt", sof_cnt, 1);
    chk("f0_eol_cnt", eol_cnt, 4);

    // frame 1: colour bars, two pixels per bar
    run_to(281); chk("f1_bp_rgb", {r, g, b}, 0);
    for (int x = 0; x < 16; x++) begin
      run_to(282 + x);
      chk($sformatf("f1_bar_x%0d", x), {r, g, b}, bar_exp[x / 2]);
    end
    chk("f1_eol", eol, 1);
    run_to(298); chk("f1_fp_rgb", {de, r, g, b}, 0);
    run_to(300); mode = 3'd3;

    // frame 2: checkerboard, 2-pixel squares
    run_to(482); chk("f2_y0_x0", {r, g, b}, 24'h000000);
    run_to(484); chk("f2_y0_x2", {r, g, b}, 24'hFFFFFF);
    run_to(486); chk("f2_y0_x4", {r, g, b}, 24'h000000);
    run_to(507); chk("f2_y1_x0", {r, g, b}, 24'h000000);
    run_to(532); chk("f2_y2_x0", {r, g, b}, 24'hFFFFFF);
    run_to(534); chk("f2_y2_x2", {r, g, b}, 24'h000000);
    run_to(550); mode = 3'd4;

    // frame 3: moving ramp, frame_cnt = 3
    run_to(682); chk("f3_x0y0", {r, g, b}, 24'h030000); chk("f3_sof", sof, 1);
    run_to(712); chk("f3_x5y1", {r, g, b}, 24'h080100); chk("f3_fcnt", frame_cnt, 3);
    run_to(750); mode = 3'd0; solid_rgb = 24'h123456;

    // frame 4: solid colour; mode/en/colour changes mid-frame must not apply
    run_to(850); mode = 3'd1; en = 1'b0; solid_rgb = 24'hABCDEF;
    run_to(882); chk("f4_solid_first", {r, g, b}, 24'h123456);
    run_to(972); chk("f4_solid_last", {r, g, b}, 24'h123456); chk("f4_eol", eol, 1);
    run_to(998); chk("f4_fcnt_before", frame_cnt, 4);
    run_to(999); chk("f4_fcnt_end", frame_cnt, 5);
    run_to(1000); chk("stop_hs", hs, 1); chk("stop_vs", vs, 1); chk("stop_de", de, 0);
    run_to(1040); chk("stop_hold_hsvs", {hs, vs, de}, 3'b110); chk("stop_fcnt", frame_cnt, 5);

    // reset during active video
    en = 1'b1; mode = 3'd2;
    step(); step(); step();
    n = 0;
    chk("rs_start_hs", hs, 0);
    run_to(87); chk("rs_pre_de", de, 1); chk("rs_pre_r", r, 5);
    rst_b = 1'b0;
    #1;
    chk("rs_async_de", de, 0); chk("rs_async_rgb", {r, g, b}, 0);
    chk("rs_async_hsvs", {hs, vs}, 2'b11); chk("rs_async_fcnt", frame_cnt, 0);
    step(); chk("rs_hold", {hs, vs, de, sof, eol}, 5'b11000);
    rst_b = 1'b1;
    step(); step(); chk("rs_arm_hs", hs, 1);
    step();
    n = 0;
    chk("rs_restart_hsvs", {hs, vs}, 2'b00);
    run_to(2); chk("rs_h2_hs", hs, 0);
    run_to(3); chk("rs_h3_hs", hs, 1);
    run_to(82);
    chk("rs_px0", {de, sof, r, g, b}, {2'b11, 24'h0}); chk("rs_fcnt", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
